// File: rtl/paint_mode_control.sv
// Top-level mode sequencer for the laser-paint pipeline: calibration, run, pause,
// canvas-clear sweep and brush-colour cycling driven by debounced button edges.
module paint_mode_control #(
   parameter int NUM_COLORS   = 4,
   parameter int CAL_FRAMES   = 8,
   parameter int IDLE_FRAMES  = 60,
   parameter int CANVAS_WORDS = 76800,
   localparam int ADDR_W = $clog2(CANVAS_WORDS),
   localparam int CIDX_W = $clog2(NUM_COLORS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              get_color,
   input  logic              pause_btn,
   input  logic              clear_btn,
   input  logic              brush_next,
   input  logic              frame_start,
   input  logic              laser_seen,
   input  logic              clear_ready,
   output logic              run,
   output logic              cal_active,
   output logic              cal_done,
   output logic              paused,
   output logic              clear_we,
   output logic [ADDR_W-1:0] clear_addr,
   output logic [CIDX_W-1:0] color_idx,
   output logic [2:0]        state_dbg
);

   localparam int FC_W = $clog2(CAL_FRAMES + 1);
   localparam int IC_W = $clog2(IDLE_FRAMES + 1);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_CAL   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_CLEAR = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [FC_W-1:0]   frame_q, frame_d;
   logic [IC_W-1:0]   idle_q, idle_d;
   logic [CIDX_W-1:0] color_q, color_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cal_done_q, cal_done_d;
   logic              auto_q, auto_d;
   logic              ret_pause_q, ret_pause_d;
   logic [3:0]        prev_q;
   logic [3:0]        btn, btn_edge;
   logic [CIDX_W-1:0] color_next;

   assign btn      = {clear_btn, get_color, pause_btn, brush_next};
   assign btn_edge = btn & ~prev_q;

   assign color_next = (color_q == CIDX_W'(NUM_COLORS - 1)) ? '0 : color_q + CIDX_W'(1);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_INIT;
         frame_q     <= '0;
         idle_q      <= '0;
         color_q     <= '0;
         addr_q      <= '0;
         cal_done_q  <= 1'b0;
         auto_q      <= 1'b0;
         ret_pause_q <= 1'b0;
         // History starts high so a button held through reset must be released first.
         prev_q      <= '1;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         idle_q      <= idle_d;
         color_q     <= color_d;
         addr_q      <= addr_d;
         cal_done_q  <= cal_done_d;
         auto_q      <= auto_d;
         ret_pause_q <= ret_pause_d;
         prev_q      <= btn;
      end
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      idle_d      = '0;
      color_d     = color_q;
      addr_d      = addr_q;
      cal_done_d  = 1'b0;
      auto_d      = auto_q;
      ret_pause_d = ret_pause_q;

      unique case (state_q)
         S_INIT: begin
            if (btn_edge[2]) begin
               state_d = S_CAL;
               frame_d = '0;
            end
         end

         S_CAL: begin
            if (btn_edge[2]) begin
               frame_d = '0;
            end else if (frame_start) begin
               if (frame_q == FC_W'(CAL_FRAMES - 1)) begin
                  state_d    = S_RUN;
                  frame_d    = '0;
                  cal_done_d = 1'b1;
               end else begin
                  frame_d = frame_q + FC_W'(1);
               end
            end
         end

         S_RUN: begin
            idle_d = idle_q;
            if (btn_edge[3]) begin
               state_d     = S_CLEAR;
               addr_d      = '0;
               ret_pause_d = 1'b0;
               idle_d      = '0;
            end else if (btn_edge[2]) begin
               state_d = S_CAL;
               frame_d = '0;
               idle_d  = '0;
            end else if (btn_edge[1]) begin
               state_d = S_PAUSE;
               auto_d  = 1'b0;
               idle_d  = '0;
            end else begin
               if (frame_start) begin
                  if (laser_seen) begin
                     idle_d = '0;
                  end else if (idle_q == IC_W'(IDLE_FRAMES - 1)) begin
                     state_d = S_PAUSE;
                     auto_d  = 1'b1;
                     idle_d  = '0;
                  end else begin
                     idle_d = idle_q + IC_W'(1);
                  end
               end
               if (btn_edge[0]) color_d = color_next;
            end
         end

         S_PAUSE: begin
            if (btn_edge[3]) begin
               state_d     = S_CLEAR;
               addr_d      = '0;
               ret_pause_d = 1'b1;
            end else if (btn_edge[2]) begin
               state_d = S_CAL;
               frame_d = '0;
            end else if (btn_edge[1]) begin
               state_d = S_RUN;
            end else begin
               if (auto_q && frame_start && laser_seen) state_d = S_RUN;
               if (btn_edge[0]) color_d = color_next;
            end
         end

         S_CLEAR: begin
            if (clear_ready) begin
               if (addr_q == ADDR_W'(CANVAS_WORDS - 1)) begin
                  state_d = ret_pause_q ? S_PAUSE : S_RUN;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end

         default: state_d = S_INIT;
      endcase
   end

   assign run        = (state_q == S_RUN);
   assign cal_active = (state_q == S_CAL);
   assign paused     = (state_q == S_PAUSE);
   assign clear_we   = (state_q == S_CLEAR);
   assign cal_done   = cal_done_q;
   assign clear_addr = addr_q;
   assign color_idx  = color_q;
   assign state_dbg  = state_q;

endmodule

// File: doc/paint_mode_control.md
Name: paint_mode_control

Overview:
- Top-level mode sequencer for the laser-paint pipeline; successor to the two-state init/run controller.
- Adds a timed colour-calibration phase, manual and automatic pause, a canvas-clear sweep that drives frame-buffer writes, and brush-colour cycling.
- Sits between the debounced button inputs / camera frame logic and the laser tracker, colour-capture unit and canvas memory.

Parameters:
- NUM_COLORS, 4: number of brush colour slots (>=2).
- CAL_FRAMES, 8: frames spent in calibration after a get_color request (>=1).
- IDLE_FRAMES, 60: consecutive frames with no laser in RUN before auto-pause (>=1).
- CANVAS_WORDS, 76800: canvas memory words cleared by a clear sweep (>=2).
- Localparams: ADDR_W = $clog2(CANVAS_WORDS); CIDX_W = $clog2(NUM_COLORS).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- get_color, in, 1: debounced level; rising edge requests calibration.
- pause_btn, in, 1: debounced level; rising edge toggles manual pause.
- clear_btn, in, 1: debounced level; rising edge requests canvas clear.
- brush_next, in, 1: debounced level; rising edge advances the brush colour.
- frame_start, in, 1: one-cycle pulse per camera frame.
- laser_seen, in, 1: laser detected in the previous frame; valid only while frame_start=1.
- clear_ready, in, 1: canvas memory accepts a write this cycle.
- run, out, 1: high only in RUN.
- cal_active, out, 1: high only in CALIBRATE.
- cal_done, out, 1: one-cycle pulse on completion of calibration.
- paused, out, 1: high only in PAUSE.
- clear_we, out, 1: clear-write strobe.
- clear_addr, out, ADDR_W: clear-write address.
- color_idx, out, CIDX_W: current brush slot.
- state_dbg, out, 3: encoding INIT=0, CALIBRATE=1, RUN=2, PAUSE=3, CLEAR=4.

Behaviour:
- Reset (async, active-high): state=INIT; all counters=0; color_idx=0; cal_done=0; clear_addr=0; all status outputs 0.
  - Edge-detect history registers reset to 1, so a button held through reset produces no edge until it is released and pressed again.
- Timing: edges are detected as (in & ~prev) on registered history. An edge at cycle N produces the state change at N+1. run, cal_active, paused, clear_we and state_dbg are decoded from the state register only; there is no input-to-output combinational path.
- Event priority when several edges occur in the same cycle: clear > get_color > pause > brush. Lower-priority edges in that cycle are discarded.
- INIT: get_color edge -> CALIBRATE. All other edges are ignored.
- CALIBRATE:
  - frame counter is cleared on entry and increments on each frame_start.
  - When the CAL_FRAMES-th frame_start occurs, next state is RUN; cal_done=1 for exactly the first RUN cycle.
  - A get_color edge restarts the count at 0. Pause, clear and brush edges are ignored.
- RUN:
  - On each frame_start: laser_seen=1 clears idle_cnt; otherwise idle_cnt increments.
  - When the miss makes idle_cnt reach IDLE_FRAMES: state -> PAUSE (auto), idle_cnt=0.
  - pause edge -> PAUSE (manual). get_color edge -> CALIBRATE. clear edge -> CLEAR with return target RUN.
  - brush edge: color_idx increments, wrapping from NUM_COLORS-1 to 0.
- PAUSE:
  - Manual pause exits to RUN only on a pause edge.
  - Auto pause exits to RUN on a pause edge, or on a frame_start with laser_seen=1.
  - get_color edge -> CALIBRATE. clear edge -> CLEAR with return target PAUSE; the manual/auto flag is kept. brush edge is accepted (wraps as in RUN).
  - idle_cnt is held at 0.
- CLEAR:
  - clear_addr=0 on entry; clear_we=1 throughout the state.
  - clear_addr increments on each cycle with clear_we & clear_ready; stalls while clear_ready=0.
  - When address CANVAS_WORDS-1 is accepted, next state is the return target; clear_we=0 from that cycle; clear_addr returns to 0.
  - All button edges are discarded. frame_start is ignored and idle_cnt is held at 0.
- Counter widths are sized so they never overflow at the parameter maxima.
- Reset asserted mid-operation (including mid-clear) aborts immediately with no further writes. Exactly CANVAS_WORDS writes are issued per completed sweep, with no duplicate addresses.

Test Plan:
(Bench parameters: CAL_FRAMES=3, IDLE_FRAMES=4, CANVAS_WORDS=16, NUM_COLORS=3.)
- Reset, then get_color edge, then 3 frame_start pulses -> state_dbg 0->1->2; cal_done high for 1 cycle, coincident with run=1; get_color held through reset gives no transition until re-pressed.
- In RUN, brush edge x4 -> color_idx 1,2,0,1; brush edge in INIT or CALIBRATE -> no change.
- In RUN, 4 frame_start pulses with laser_seen=0 -> PAUSE after the 4th; next frame_start with laser_seen=1 -> RUN. Repeat with manual pause: a laser_seen=1 frame keeps PAUSE; a pause edge returns to RUN.
- From PAUSE, clear edge with clear_ready toggling 1,0,1,... -> addresses 0..15 each written once; state returns to PAUSE (3); pause/brush edges during the sweep have no effect.
- Same cycle clear edge + pause edge + brush edge in RUN -> CLEAR only; color_idx unchanged.
- Async reset asserted at clear_addr=7 -> clear_we=0, state_dbg=0 and all outputs 0 within the same cycle, before the next clk edge.
